arith_seq: RTL
==============

Name: arith_seq

Overview:
- Micro-operation sequencer directly upstream of the arithmetic unit (A/B/C registers, 31-bit B with overflow bit 0).
- Accepts one arithmetic command from the main controller and issues the timed do_* strobes for it: single-step ADD/SUB/AND/CLRB, iterative shift-add MUL, multi-cycle SHL.
- Samples the unit's status bits (reg_d_0, reg_b_0, reg_c_30), then reports done/overflow/err.

Parameters:
- MUL_ITERS, 30, shift-add iterations per MUL.
- CNT_W, 5, iteration/shift counter width; must hold MUL_ITERS and 31.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- start  in  1  command valid; accepted only when ready=1
- op  in  3  0 ADD, 1 SUB, 2 AND, 3 MUL, 4 SHL, 5 CLRB, 6/7 illegal
- shamt  in  5  SHL shift count, sampled at accept
- abort  in  1  cancel current command
- ready  out  1  high only in IDLE
- done  out  1  one-cycle completion pulse
- overflow  out  1  command overflow result, valid from done until next accept
- err  out  1  illegal-op flag, valid from done until next accept
- reg_d_0  in  1  carry-out of A+B+carry_in (combinational from unit)
- reg_b_0  in  1  B overflow bit
- reg_c_30  in  1  C least-significant bit
- do_sum, do_not_a, do_and, do_clear_b, do_right_shift_bc, do_left_shift_b  out  1 each  strobes to arithmetic unit

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clk.
  - On reset: state IDLE, ready=1, done=0, overflow=0, err=0, counter=0, all do_* = 0.
  - Reset mid-command abandons it with no further strobes.
- Structure: Moore outputs decoded from the registered state.
  - At most one do_* is high per cycle.
  - The first strobe appears in the cycle after acceptance.
- Accept: start & ready at an edge. Latch op and shamt; clear overflow and err.
- States: IDLE, ADD, SUB_NEG, SUB_ADD, SUB_RST, AND, CLRB, MUL_TEST, MUL_ADD, MUL_SHIFT, SHL, DONE.
- Per-op sequences (n = accept cycle; done is high during DONE):
  - ADD: cycle n+1 do_sum; overflow <= reg_d_0 sampled that cycle. DONE at n+2.
  - SUB: n+1 do_not_a, n+2 do_sum (overflow <= reg_d_0), n+3 do_not_a (restores A). DONE at n+4.
  - AND: n+1 do_and. DONE at n+2; overflow=0.
  - CLRB: n+1 do_clear_b. DONE at n+2.
  - MUL: counter <= MUL_ITERS.
    - MUL_TEST drives no strobe: reg_c_30=1 goes to MUL_ADD, else to MUL_SHIFT.
    - MUL_ADD: do_sum; overflow |= reg_d_0; then MUL_SHIFT.
    - MUL_SHIFT: do_right_shift_bc; counter-1; if counter==1 go to DONE, else MUL_TEST.
    - Total 2*MUL_ITERS + (number of add iterations) strobe/test cycles.
  - SHL: counter <= shamt.
    - shamt=0: straight to DONE, no strobes.
    - Otherwise SHL asserts do_left_shift_b for exactly shamt cycles.
    - overflow |= reg_b_0, sampled in each SHL cycle after the first and in the DONE cycle.
  - Illegal op: DONE at n+1, err=1, no strobes.
- DONE: done=1 for one cycle, ready=0; next state IDLE.
  - The earliest next accept is the cycle after DONE.
- abort in any non-IDLE state: next state IDLE with no DONE pulse. Strobes stop from the next cycle; overflow and err are unchanged.
  - abort in IDLE is ignored.
  - abort together with start in IDLE: the start is ignored.
- start while not ready is ignored; no queuing.

Decomposition:
- Shared package arith_pkg holds:
  - op encodings OP_ADD..OP_CLRB;
  - state enum typedef arith_seq_state_t;
  - MUL_ITERS default constant.
- No sub-module. The strobe decode is a single case on state, and the counter is inline.

Test Plan:
- Reset → ready=1, done=0, overflow=0, err=0, all do_* 0. Then ADD with reg_d_0=1 → do_sum at n+1 only, done at n+2, overflow=1.
- SUB → do_not_a, do_sum, do_not_a on n+1..n+3, no other strobes, done at n+4. With reg_d_0=0 during do_sum, overflow=0.
- MUL, MUL_ITERS=30, reg_c_30 driven 1 on iterations 0,5,29 only → exactly 3 do_sum, 30 do_right_shift_bc, done at n+64. reg_d_0=1 on one add → overflow=1.
- SHL shamt=3, reg_b_0 rising to 1 after the second shift → 3 consecutive do_left_shift_b, overflow=1. SHL shamt=0 → done at n+1, no strobe.
- op=6 → done at n+1, err=1, no strobe. Next ADD → err cleared at accept.
- MUL aborted at iteration 10 → strobes stop, no done pulse, ready=1 the next cycle. start held during busy → ignored. resetn low mid-MUL → all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared encodings for the arithmetic micro-op sequencer: opcodes, FSM states,
// and the default multiply iteration count.
package arith_pkg;

    localparam int MUL_ITERS_DEFAULT = 30;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_SHL  = 3'd4;
    localparam logic [2:0] OP_CLRB = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADD,
        S_SUB_NEG,
        S_SUB_ADD,
        S_SUB_RST,
        S_AND,
        S_CLRB,
        S_MUL_TEST,
        S_MUL_ADD,
        S_MUL_SHIFT,
        S_SHL,
        S_DONE
    } arith_seq_state_t;

endpackage

// File: rtl/arith_seq.sv
// Sequencer that turns one arithmetic command into timed do_* strobes for the
// A/B/C arithmetic unit and reports done/overflow/err from its status bits.
module arith_seq
    import arith_pkg::*;
#(
    parameter int MUL_ITERS = MUL_ITERS_DEFAULT,
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [4:0] shamt,
    input  logic       abort,
    output logic       ready,
    output logic       done,
    output logic       overflow,
    output logic       err,
    input  logic       reg_d_0,
    input  logic       reg_b_0,
    input  logic       reg_c_30,
    output logic       do_sum,
    output logic       do_not_a,
    output logic       do_and,
    output logic       do_clear_b,
    output logic       do_right_shift_bc,
    output logic       do_left_shift_b
);

    arith_seq_state_t state;
    logic [2:0]       op_q;
    logic [4:0]       shamt_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            op_q     <= OP_ADD;
            shamt_q  <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            err      <= 1'b0;
        end else if (abort && state != S_IDLE) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        op_q     <= op;
                        shamt_q  <= shamt;
                        overflow <= 1'b0;
                        err      <= 1'b0;
                        case (op)
                            OP_ADD:  state <= S_ADD;
                            OP_SUB:  state <= S_SUB_NEG;
                            OP_AND:  state <= S_AND;
                            OP_CLRB: state <= S_CLRB;
                            OP_MUL: begin
                                cnt   <= CNT_W'(MUL_ITERS);
                                state <= S_MUL_TEST;
                            end
                            OP_SHL: begin
                                cnt   <= CNT_W'(shamt);
                                state <= (shamt == 5'd0) ? S_DONE : S_SHL;
                            end
                            default: begin
                                err   <= 1'b1;
                                state <= S_DONE;
                            end
                        endcase
                    end
                end
                S_ADD: begin
                    overflow <= reg_d_0;
                    state    <= S_DONE;
                end
                S_SUB_NEG: state <= S_SUB_ADD;
                S_SUB_ADD: begin
                    overflow <= reg_d_0;
                    state    <= S_SUB_RST;
                end
                S_SUB_RST: state <= S_DONE;
                S_AND: begin
                    overflow <= 1'b0;
                    state    <= S_DONE;
                end
                S_CLRB:     state <= S_DONE;
                S_MUL_TEST: state <= reg_c_30 ? S_MUL_ADD : S_MUL_SHIFT;
                S_MUL_ADD: begin
                    overflow <= overflow | reg_d_0;
                    state    <= S_MUL_SHIFT;
                end
                S_MUL_SHIFT: begin
                    cnt   <= cnt - CNT_W'(1);
                    state <= (cnt == CNT_W'(1)) ? S_DONE : S_MUL_TEST;
                end
                S_SHL: begin
                    // The bit shifted out by the first shift is not yet in B[0].
                    if (cnt != CNT_W'(shamt_q))
                        overflow <= overflow | reg_b_0;
                    cnt   <= cnt - CNT_W'(1);
                    state <= (cnt == CNT_W'(1)) ? S_DONE : S_SHL;
                end
                S_DONE: begin
                    if (op_q == OP_SHL && shamt_q != 5'd0)
                        overflow <= overflow | reg_b_0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ready             = 1'b0;
        done              = 1'b0;
        do_sum            = 1'b0;
        do_not_a          = 1'b0;
        do_and            = 1'b0;
        do_clear_b        = 1'b0;
        do_right_shift_bc = 1'b0;
        do_left_shift_b   = 1'b0;
        case (state)
            S_IDLE:      ready             = 1'b1;
            S_ADD:       do_sum            = 1'b1;
            S_SUB_NEG:   do_not_a          = 1'b1;
            S_SUB_ADD:   do_sum            = 1'b1;
            S_SUB_RST:   do_not_a          = 1'b1;
            S_AND:       do_and            = 1'b1;
            S_CLRB:      do_clear_b        = 1'b1;
            S_MUL_ADD:   do_sum            = 1'b1;
            S_MUL_SHIFT: do_right_shift_bc = 1'b1;
            S_SHL:       do_left_shift_b   = 1'b1;
            S_DONE:      done              = 1'b1;
            default:     ;
        endcase
    end

endmodule
